// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Two-requester (ALU / load) arbiter onto a single register-file
//            write port, age-ordered, with PC-write squash and optional
//            pending-write scoreboard (enable with `define SCOREBOARD_EN).
// Revision : 1.0
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int PC_INDEX   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  aluValid,
    input  logic [ADDR_WIDTH-1:0] aluDest,
    input  logic [DATA_WIDTH-1:0] aluData,
    output logic                  aluReady,
    input  logic                  memValid,
    input  logic [ADDR_WIDTH-1:0] memDest,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic                  memReady,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] writeDestination,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  pcWrite,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    output logic                  readHazard1,
    output logic                  readHazard2
);

    localparam logic [ADDR_WIDTH-1:0] c_pcIndex = PC_INDEX[ADDR_WIDTH-1:0];
    localparam int                    c_numRegs = 1 << ADDR_WIDTH;

    logic                  r_aluFull, r_memFull, r_aluOlder;
    logic [ADDR_WIDTH-1:0] r_aluDest, r_memDest;
    logic [DATA_WIDTH-1:0] r_aluData, r_memData;

    logic                  w_grantAlu, w_grantMem, w_grant;
    logic                  w_squashAlu, w_squashMem;
    logic                  w_aluCapture, w_memCapture;
    logic                  w_aluFullNext, w_memFullNext;
    logic [ADDR_WIDTH-1:0] w_aluDestNext, w_memDestNext, w_issueDest;
    logic [DATA_WIDTH-1:0] w_issueData;

    // A PC write squashes whatever the other side holds or is accepting now;
    // that entry is always younger because the older side is granted first.
    always_comb begin
        w_grantAlu    = r_aluFull && (!r_memFull || r_aluOlder);
        w_grantMem    = r_memFull && !w_grantAlu;
        w_grant       = w_grantAlu || w_grantMem;
        w_squashAlu   = w_grantMem && (r_memDest == c_pcIndex);
        w_squashMem   = w_grantAlu && (r_aluDest == c_pcIndex);
        w_aluCapture  = aluValid && !r_aluFull && !flush && !w_squashAlu;
        w_memCapture  = memValid && !r_memFull && !flush && !w_squashMem;
        w_aluFullNext = w_aluCapture || (r_aluFull && !w_grantAlu && !flush && !w_squashAlu);
        w_memFullNext = w_memCapture || (r_memFull && !w_grantMem && !flush && !w_squashMem);
        w_aluDestNext = w_aluCapture ? aluDest : r_aluDest;
        w_memDestNext = w_memCapture ? memDest : r_memDest;
        w_issueDest   = w_grantAlu ? r_aluDest : r_memDest;
        w_issueData   = w_grantAlu ? r_aluData : r_memData;
    end

    assign aluReady = !r_aluFull;
    assign memReady = !r_memFull;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_aluFull  <= 1'b0;
            r_memFull  <= 1'b0;
            r_aluOlder <= 1'b0;
            r_aluDest  <= '0;
            r_memDest  <= '0;
            r_aluData  <= '0;
            r_memData  <= '0;
        end else begin
            r_aluFull <= w_aluFullNext;
            r_memFull <= w_memFullNext;
            if (w_aluCapture) begin
                r_aluDest <= aluDest;
                r_aluData <= aluData;
            end
            if (w_memCapture) begin
                r_memDest <= memDest;
                r_memData <= memData;
            end
            // Newly captured entry is the younger one; same-edge pair favours mem.
            if (w_aluCapture)
                r_aluOlder <= 1'b0;
            else if (w_memCapture)
                r_aluOlder <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            writeEnable      <= 1'b0;
            pcWrite          <= 1'b0;
            writeDestination <= '0;
            writeData        <= '0;
        end else if (w_grant) begin
            writeEnable      <= 1'b1;
            pcWrite          <= (w_issueDest == c_pcIndex);
            writeDestination <= w_issueDest;
            writeData        <= w_issueData;
        end else begin
            writeEnable      <= 1'b0;
            pcWrite          <= 1'b0;
        end
    end

`ifdef SCOREBOARD_EN
    logic [c_numRegs-1:0] r_pending, w_pendingNext;

    // Mask tracks every entry that will sit in a buffer or the write stage.
    always_comb begin
        w_pendingNext = '0;
        if (w_aluFullNext)
            w_pendingNext[w_aluDestNext] = 1'b1;
        if (w_memFullNext)
            w_pendingNext[w_memDestNext] = 1'b1;
        if (w_grant)
            w_pendingNext[w_issueDest] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_pending <= '0;
        else
            r_pending <= w_pendingNext;
    end

    assign readHazard1 = r_pending[readReg1];
    assign readHazard2 = r_pending[readReg2];
`else
    logic w_unusedProbe;
    assign w_unusedProbe = ^{readReg1, readReg2, w_aluDestNext, w_memDestNext, c_numRegs[0]};
    assign readHazard1   = 1'b0;
    assign readHazard2   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Scoreboard bench for regfile_write_arbiter; expected writes are
//            queued at stimulus time and popped as writeEnable appears.
// Revision : 1.0
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        aluValid, memValid, aluReady, memReady;
    logic [3:0]  aluDest, memDest, writeDestination, readReg1, readReg2;
    logic [31:0] aluData, memData, writeData;
    logic        writeEnable, pcWrite, readHazard1, readHazard2;

    logic [36:0] expQ[$];
    logic [31:0] regs[16];
    int          vecCount  = 0;
    int          missCount = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .PC_INDEX(15)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .aluValid(aluValid), .aluDest(aluDest), .aluData(aluData), .aluReady(aluReady),
        .memValid(memValid), .memDest(memDest), .memData(memData), .memReady(memReady),
        .writeEnable(writeEnable), .writeDestination(writeDestination),
        .writeData(writeData), .pcWrite(pcWrite),
        .readReg1(readReg1), .readReg2(readReg2),
        .readHazard1(readHazard1), .readHazard2(readHazard2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every observed write must be the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && writeEnable === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected_write", {27'd0, pcWrite, writeDestination, writeData}, 64'd0);
            end else begin
                check("write", {27'd0, pcWrite, writeDestination, writeData}, {27'd0, expQ.pop_front()});
            end
            regs[writeDestination] = writeData;
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0;
        aluValid = 1'b0; aluDest = '0; aluData = '0;
        memValid = 1'b0; memDest = '0; memData = '0;
        readReg1 = 4'd8; readReg2 = 4'd3;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_we", writeEnable, 0);
        check("rst_pc", pcWrite, 0);
        check("rst_dest", writeDestination, 0);
        check("rst_data", writeData, 0);
        check("rst_ready", {aluReady, memReady}, 2'b11);
        check("rst_haz", {readHazard1, readHazard2}, 2'b00);

        // single ALU write
        aluValid = 1'b1; aluDest = 4'd8; aluData = 32'hAAAAAAAA;
        expQ.push_back({1'b0, 4'd8, 32'hAAAAAAAA});
        tick();
        aluValid = 1'b0;
        check("t1_aluready_low", aluReady, 0);
        check("t1_we_low", writeEnable, 0);
`ifdef SCOREBOARD_EN
        check("t1_haz_set", {readHazard1, readHazard2}, 2'b10);
`else
        check("t1_haz_tied", {readHazard1, readHazard2}, 2'b00);
`endif
        tick();
        check("t1_we", writeEnable, 1);
        check("t1_dest", writeDestination, 8);
        check("t1_data", writeData, 32'hAAAAAAAA);
        check("t1_aluready_back", aluReady, 1);
        tick();
        check("t1_we_once", writeEnable, 0);
        check("t1_haz_clear", {readHazard1, readHazard2}, 2'b00);

        // same-edge pair to one register: mem first, ALU last
        aluValid = 1'b1; aluDest = 4'd0; aluData = 32'h11111111;
        memValid = 1'b1; memDest = 4'd0; memData = 32'h22222222;
        expQ.push_back({1'b0, 4'd0, 32'h22222222});
        expQ.push_back({1'b0, 4'd0, 32'h11111111});
        tick();
        aluValid = 1'b0; memValid = 1'b0;
        check("t2_ready_low", {aluReady, memReady}, 2'b00);
        tick();
        check("t2_first", writeData, 32'h22222222);
        tick();
        check("t2_second", writeData, 32'h11111111);
        check("t2_we_second", writeEnable, 1);
        tick();
        check("t2_we_done", writeEnable, 0);
        check("t2_reg0", regs[0], 32'h11111111);

        // mem one edge ahead of ALU, same dest, back-to-back
        memValid = 1'b1; memDest = 4'd3; memData = 32'h33333333;
        expQ.push_back({1'b0, 4'd3, 32'h33333333});
        tick();
        memValid = 1'b0;
        aluValid = 1'b1; aluDest = 4'd3; aluData = 32'h44444444;
        expQ.push_back({1'b0, 4'd3, 32'h44444444});
        tick();
        aluValid = 1'b0;
        check("t3_first", {writeEnable, writeData}, {1'b1, 32'h33333333});
        tick();
        check("t3_second", {writeEnable, writeData}, {1'b1, 32'h44444444});
        check("t3_ready", {aluReady, memReady}, 2'b11);
        tick();
        check("t3_we_done", writeEnable, 0);

        // PC write squashes the younger load
        aluValid = 1'b1; aluDest = 4'd15; aluData = 32'hCCCCCCCC;
        expQ.push_back({1'b1, 4'd15, 32'hCCCCCCCC});
        tick();
        aluValid = 1'b0;
        memValid = 1'b1; memDest = 4'd2; memData = 32'hDDDDDDDD;
        tick();
        memValid = 1'b0;
        check("t4_pc", {writeEnable, pcWrite, writeDestination}, {1'b1, 1'b1, 4'd15});
        check("t4_memready", memReady, 1);
        tick();
        check("t4_no_load", {writeEnable, pcWrite}, 2'b00);
        tick();
        check("t4_still_idle", writeEnable, 0);
        check("t4_reg2", regs[2], 0);

        // flush with a grant on the same edge
        readReg1 = 4'd5; readReg2 = 4'd6;
        aluValid = 1'b1; aluDest = 4'd5; aluData = 32'h55555555;
        memValid = 1'b1; memDest = 4'd6; memData = 32'h66666666;
        expQ.push_back({1'b0, 4'd6, 32'h66666666});
        tick();
        aluValid = 1'b0; memValid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_stage", {writeEnable, writeData}, {1'b1, 32'h66666666});
        check("t5_ready", {aluReady, memReady}, 2'b11);
        tick();
        check("t5_no_more", writeEnable, 0);
        tick();
        check("t5_idle", writeEnable, 0);
        check("t5_haz", {readHazard1, readHazard2}, 2'b00);

        // reset while both buffers full
        aluValid = 1'b1; aluDest = 4'd7; aluData = 32'h77777777;
        memValid = 1'b1; memDest = 4'd9; memData = 32'h99999999;
        tick();
        aluValid = 1'b0; memValid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_out", {writeEnable, pcWrite, writeDestination, writeData}, 38'd0);
        check("t6_ready", {aluReady, memReady}, 2'b11);
        tick();
        check("t6_we", writeEnable, 0);
        repeat (3) tick();
        check("drain", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
`default_nettype wire
